// File: rtl/cmem_arbiter_if.sv
// Requester and layer-memory signal bundle for the three-way layer-memory arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface cmem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 20
);
    logic [2:0]      req;
    logic [2:0]      lock;
    logic [2:0]      we;
    logic [8:0]      sel;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            idle;
    logic [2:0]      csel;
    logic            crd;
    logic            cwr;
    logic [AW-1:0]   caddr_rd;
    logic [AW-1:0]   caddr_wr;
    logic [DW-1:0]   cdata_wr;
    logic [DW-1:0]   cdata_rd;

    modport slave (
        input  req, lock, we, sel, addr, wdata, cdata_rd,
        output gnt, rvalid, rdata, idle, csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr
    );

    modport master (
        output req, lock, we, sel, addr, wdata, cdata_rd,
        input  gnt, rvalid, rdata, idle, csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr
    );
endinterface

// File: rtl/cmem_arbiter.sv
// Round-robin arbiter sharing one layer-memory port among three engines, with
// fairness-bounded locked bursts and a fixed-latency read tag return path.
module cmem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 20,
    parameter int RD_LAT   = 1,
    parameter int MAXBURST = 16
) (
    input  logic           clk,
    input  logic           reset,
    cmem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {ST_ARB = 1'b0, ST_OWN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2:0]      gnt;
    logic [2:0]      others;
    logic            own_grant;
    logic            gany;
    logic [1:0]      gidx;

    logic [2:0]      sel_g;
    logic [AW-1:0]   addr_g;
    logic [DW-1:0]   wdata_g;
    logic            we_g;
    logic            do_cmd;

    logic [2:0]      csel_q, csel_d;
    logic            crd_q, crd_d;
    logic            cwr_q, cwr_d;
    logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
    logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
    logic            idle_q, idle_d;

    logic [RD_LAT:0] tag_v_q;
    logic [1:0]      tag_id_q [RD_LAT+1];
    logic [2:0]      rvalid;

    // First requesting index at or after p, scanning cyclically.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] g;
        int idx;
        g = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(p) + k) % 3;
            if (r[idx]) g = 3'b001 << idx;
        end
        return g;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner keeps the port unless it has used its fair share while others wait.
    always_comb begin
        others    = bus.req & ~(3'b001 << owner_q);
        own_grant = (state_q == ST_OWN) && bus.req[owner_q] &&
                    ((cnt_q < CW'(MAXBURST)) || (others == 3'b000));
        if (own_grant) gnt = 3'b001 << owner_q;
        else           gnt = rr_pick(bus.req, ptr_q);
        gany = |gnt;
        gidx = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (gany) ptr_d = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        if (own_grant) begin
            if (cnt_q != CW'(MAXBURST)) cnt_d = cnt_q + 1'b1;
            if (!bus.lock[owner_q]) begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        end else begin
            state_d = ST_ARB;
            cnt_d   = '0;
            if (gany && bus.lock[gidx]) begin
                state_d = ST_OWN;
                owner_d = gidx;
                cnt_d   = CW'(1);
            end
        end
    end

    always_comb begin
        sel_g      = bus.sel[3*int'(gidx) +: 3];
        addr_g     = bus.addr[AW*int'(gidx) +: AW];
        wdata_g    = bus.wdata[DW*int'(gidx) +: DW];
        we_g       = bus.we[gidx];
        // Illegal selects still consume the grant but never reach the bus.
        do_cmd     = gany && (sel_g != 3'd0) && (sel_g <= 3'd5);
        csel_d     = do_cmd ? sel_g : 3'd0;
        crd_d      = do_cmd && !we_g;
        cwr_d      = do_cmd && we_g;
        caddr_rd_d = crd_d ? addr_g : caddr_rd_q;
        caddr_wr_d = cwr_d ? addr_g : caddr_wr_q;
        cdata_wr_d = cwr_d ? wdata_g : cdata_wr_q;
        idle_d     = !gany && !(|tag_v_q[RD_LAT-1:0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csel_q     <= 3'd0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            idle_q     <= 1'b1;
        end else begin
            csel_q     <= csel_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            idle_q     <= idle_d;
        end
    end

    // The tag enters with the bus strobe and emerges when memory data is valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_q <= '0;
            for (int k = 0; k <= RD_LAT; k++) tag_id_q[k] <= 2'd0;
        end else begin
            tag_v_q     <= {tag_v_q[RD_LAT-1:0], crd_d};
            tag_id_q[0] <= gidx;
            for (int k = 1; k <= RD_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rvalid
            assign rvalid[gi] = tag_v_q[RD_LAT] && (tag_id_q[RD_LAT] == 2'(gi));
        end
    endgenerate

    assign bus.gnt      = gnt;
    assign bus.rvalid   = rvalid;
    assign bus.rdata    = bus.cdata_rd;
    assign bus.idle     = idle_q;
    assign bus.csel     = csel_q;
    assign bus.crd      = crd_q;
    assign bus.cwr      = cwr_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed and random stimulus for cmem_arbiter, checked cycle by cycle against
// a behavioural model of grants, bus commands and read returns.
module tb_cmem_arbiter;
    parameter int RD_LAT = 1;
    localparam int AW   = 12;
    localparam int DW   = 20;
    localparam int MAXB = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmem_arbiter_if #(.AW(AW), .DW(DW)) bif ();

    cmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAXBURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int            m_ptr, m_own, m_cnt;
    bit            m_locked;
    logic [2:0]    m_csel;
    logic          m_crd, m_cwr, m_idle;
    logic [AW-1:0] m_ard, m_awr;
    logic [DW-1:0] m_dwr;
    logic [2:0]    rv_ring [64];
    logic [DW-1:0] cdata_val;
    logic [2:0]    obs_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_own = 0; m_cnt = 0; m_locked = 0;
        m_csel = 0; m_crd = 0; m_cwr = 0; m_idle = 1;
        m_ard = 0; m_awr = 0; m_dwr = 0;
        for (int k = 0; k < 64; k++) rv_ring[k] = 3'b000;
    endtask

    // One clock: check the combinational grant, advance the model, check registered outputs.
    task automatic step();
        int g;
        logic [2:0] exp_g, others, s;
        logic w, pend;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        g = -1;
        others = bif.req & ~(3'b001 << m_own);
        if (m_locked && bif.req[m_own] && (m_cnt < MAXB || others == 3'b000)) g = m_own;
        else for (int k = 0; k < 3; k++) if (g < 0 && bif.req[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        exp_g = (g < 0) ? 3'b000 : 3'b001 << g;
        obs_gnt = bif.gnt;
        chk("gnt", bif.gnt, exp_g);
        if (g >= 0) begin
            if (m_locked && g == m_own) begin
                m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
                m_locked = bif.lock[g];
            end else if (bif.lock[g]) begin
                m_locked = 1; m_own = g; m_cnt = 1;
            end else m_locked = 0;
            m_ptr = (g + 1) % 3;
            s = bif.sel[3*g +: 3]; w = bif.we[g];
            a = bif.addr[AW*g +: AW]; d = bif.wdata[DW*g +: DW];
            if (s >= 3'd1 && s <= 3'd5) begin
                m_csel = s; m_crd = !w; m_cwr = w;
                if (w) begin m_awr = a; m_dwr = d; end
                else begin
                    m_ard = a;
                    rv_ring[(cyc + 1 + RD_LAT) % 64] = rv_ring[(cyc + 1 + RD_LAT) % 64] | exp_g;
                end
            end else begin m_csel = 0; m_crd = 0; m_cwr = 0; end
        end else begin
            m_locked = 0; m_csel = 0; m_crd = 0; m_cwr = 0;
        end
        pend = 0;
        for (int k = 1; k <= RD_LAT + 1; k++) pend = pend | (|rv_ring[(cyc + k) % 64]);
        m_idle = (g < 0) && !pend;
        @(posedge clk); #1;
        cyc++;
        cdata_val = DW'($urandom);
        bif.cdata_rd = cdata_val;
        #1;
        chk("csel", bif.csel, m_csel);
        chk("crd", bif.crd, m_crd);
        chk("cwr", bif.cwr, m_cwr);
        chk("caddr_rd", bif.caddr_rd, m_ard);
        chk("caddr_wr", bif.caddr_wr, m_awr);
        chk("cdata_wr", bif.cdata_wr, m_dwr);
        chk("idle", bif.idle, m_idle);
        chk("rvalid", bif.rvalid, rv_ring[cyc % 64]);
        if (rv_ring[cyc % 64] != 3'b000) chk("rdata", bif.rdata, cdata_val);
        rv_ring[cyc % 64] = 3'b000;
    endtask

    task automatic do_reset();
        bif.req = 0; bif.lock = 0;
        reset = 1'b0;
        #1;
        chk("rst_crd", bif.crd, 0);
        chk("rst_cwr", bif.cwr, 0);
        chk("rst_csel", bif.csel, 0);
        chk("rst_rvalid", bif.rvalid, 0);
        chk("rst_idle", bif.idle, 1);
        chk("rst_caddr_rd", bif.caddr_rd, 0);
        chk("rst_caddr_wr", bif.caddr_wr, 0);
        chk("rst_cdata_wr", bif.cdata_wr, 0);
        model_reset();
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    initial begin
        int streak, best, n2;
        logic [2:0] rr_exp [6];
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        bif.req = 0; bif.lock = 0; bif.we = 0; bif.sel = 0;
        bif.addr = 0; bif.wdata = 0; bif.cdata_rd = 0;
        @(posedge clk); #1;
        do_reset();

        // Single read by requester 1
        bif.req = 3'b010; bif.we = 3'b000; bif.sel = 9'(3) << 3; bif.addr = 36'(12'h040) << AW;
        step();
        chk("single_crd", bif.crd, 1);
        chk("single_addr", bif.caddr_rd, 12'h040);
        bif.req = 3'b000;
        step();
        step();
        step();

        // Three-way contention, no lock
        do_reset();
        bif.req = 3'b111; bif.lock = 3'b000; bif.we = 3'b000; bif.sel = {3'd2, 3'd2, 3'd2};
        bif.addr = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_order", obs_gnt, rr_exp[i]);
            chk("rr_busy", bif.idle, 0);
        end
        bif.req = 0;
        step(); step(); step();

        // Locked burst by requester 2 against requester 0
        do_reset();
        bif.req = 3'b101; bif.lock = 3'b100; bif.we = 3'b101; bif.sel = {3'd4, 3'd0, 3'd1};
        streak = 0; best = 0;
        for (int i = 0; i < 20; i++) begin
            bif.wdata = {$urandom, $urandom};
            step();
            streak = (obs_gnt == 3'b100) ? streak + 1 : 0;
            if (streak > best) best = streak;
        end
        chk("burst_limit", best, MAXB);
        bif.req = 3'b100; n2 = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_gnt == 3'b100) n2++;
        end
        chk("burst_alone", n2, 20);

        // Write then read of the same location
        bif.lock = 0; bif.req = 0;
        step();
        bif.req = 3'b001; bif.we = 3'b001; bif.sel = 9'd1; bif.addr = 36'd5; bif.wdata = 60'h0ABCD;
        step();
        chk("wr_cwr", bif.cwr, 1);
        chk("wr_addr", bif.caddr_wr, 5);
        chk("wr_data", bif.cdata_wr, 20'h0ABCD);
        bif.req = 3'b010; bif.we = 3'b000; bif.sel = 9'd1 << 3; bif.addr = 36'd5 << AW;
        step();
        chk("rd_crd", bif.crd, 1);
        bif.req = 0;
        step(); step(); step();

        // Random traffic, including illegal selects and locks
        for (int i = 0; i < 400; i++) begin
            bif.req   = 3'($urandom);
            bif.lock  = 3'($urandom) & 3'($urandom);
            bif.we    = 3'($urandom);
            bif.sel   = 9'($urandom);
            bif.addr  = {$urandom, $urandom};
            bif.wdata = {$urandom, $urandom};
            step();
        end

        // Reset one cycle after a read grant discards the in-flight tag
        bif.req = 3'b001; bif.lock = 0; bif.we = 0; bif.sel = 9'd2; bif.addr = 36'h123;
        step();
        chk("pre_rst_crd", bif.crd, 1);
        do_reset();
        for (int i = 0; i < RD_LAT + 3; i++) begin
            step();
            chk("post_rst_rvalid", bif.rvalid, 0);
        end
        bif.req = 3'b110;
        step();
        chk("post_rst_first", obs_gnt, 3'b010);
        bif.req = 0;
        for (int i = 0; i < RD_LAT + 2; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
